// File: rtl/router_pkt_fifo.sv
`default_nettype none
// ============================================================================
// Module      : router_pkt_fifo
// Description : Packet-aware output-channel FIFO for the router, tracking the
//               remaining length of the packet being read. Optional sticky
//               error flags are built when ROUTER_FIFO_ERR_FLAGS_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module router_pkt_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int LEN_LSB    = 2,
    parameter int LEN_WIDTH  = 6,
    parameter int AF_THRESH  = DEPTH - 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         soft_reset,
    input  logic                         write_enable,
    input  logic                         lfd_state,
    input  logic [DATA_WIDTH-1:0]        data_in,
    input  logic                         read_enable,
    output logic [DATA_WIDTH-1:0]        data_out,
    output logic                         data_valid,
    output logic                         full,
    output logic                         empty,
    output logic                         almost_full,
    output logic [$clog2(DEPTH):0]       fill_level,
    output logic [LEN_WIDTH:0]           rem_count,
    output logic                         pkt_end,
    output logic                         overflow_err,
    output logic                         underflow_err
);

    localparam int              c_AW      = $clog2(DEPTH);
    localparam logic [c_AW:0]   c_AF      = AF_THRESH[c_AW:0];
    localparam logic [LEN_WIDTH:0] c_REM_ONE = {{LEN_WIDTH{1'b0}}, 1'b1};

    logic [DATA_WIDTH:0]  r_mem [DEPTH];
    logic [c_AW:0]        r_wr_ptr;
    logic [c_AW:0]        r_rd_ptr;
    logic [DATA_WIDTH-1:0] r_data_out;
    logic                 r_data_valid;
    logic [LEN_WIDTH:0]   r_rem;
    logic                 r_pkt_end;

    logic                 w_wr_ok;
    logic                 w_rd_ok;
    logic [DATA_WIDTH:0]  w_rd_word;
    logic                 w_rd_sof;
    logic [LEN_WIDTH-1:0] w_rd_len;

    // Status flags derive purely from the extra-MSB pointer pair.
    assign empty       = (r_wr_ptr == r_rd_ptr);
    assign full        = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                         (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);
    assign fill_level  = r_wr_ptr - r_rd_ptr;
    assign almost_full = (fill_level >= c_AF);

    assign w_wr_ok   = write_enable && !full && !soft_reset;
    assign w_rd_ok   = read_enable && !empty && !soft_reset;
    assign w_rd_word = r_mem[r_rd_ptr[c_AW-1:0]];
    assign w_rd_sof  = w_rd_word[DATA_WIDTH];
    assign w_rd_len  = w_rd_word[LEN_LSB +: LEN_WIDTH];

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (w_wr_ok) begin
            r_mem[r_wr_ptr[c_AW-1:0]] <= {lfd_state, data_in};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_data_out   <= '0;
            r_data_valid <= 1'b0;
            r_rem        <= '0;
            r_pkt_end    <= 1'b0;
        end else if (soft_reset) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_data_out   <= '0;
            r_data_valid <= 1'b0;
            r_rem        <= '0;
            r_pkt_end    <= 1'b0;
        end else begin
            r_data_valid <= w_rd_ok;
            r_pkt_end    <= 1'b0;
            if (w_wr_ok) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_rd_ok) begin
                r_rd_ptr   <= r_rd_ptr + 1'b1;
                r_data_out <= w_rd_word[DATA_WIDTH-1:0];
                // A header always restarts the count: payload plus parity.
                if (w_rd_sof) begin
                    r_rem <= {1'b0, w_rd_len} + c_REM_ONE;
                end else if (r_rem != '0) begin
                    r_rem     <= r_rem - c_REM_ONE;
                    r_pkt_end <= (r_rem == c_REM_ONE);
                end
            end
        end
    end

    assign data_out   = r_data_out;
    assign data_valid = r_data_valid;
    assign rem_count  = r_rem;
    assign pkt_end    = r_pkt_end;

`ifdef ROUTER_FIFO_ERR_FLAGS_EN
    logic r_ovf;
    logic r_udf;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ovf <= 1'b0;
            r_udf <= 1'b0;
        end else if (soft_reset) begin
            r_ovf <= 1'b0;
            r_udf <= 1'b0;
        end else begin
            if (write_enable && full) begin
                r_ovf <= 1'b1;
            end
            if (read_enable && empty) begin
                r_udf <= 1'b1;
            end
        end
    end

    assign overflow_err  = r_ovf;
    assign underflow_err = r_udf;
`else
    assign overflow_err  = 1'b0;
    assign underflow_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_router_pkt_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_router_pkt_fifo
// Description : Directed self-checking bench for router_pkt_fifo (DEPTH=16).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_router_pkt_fifo;

    logic       clk;
    logic       reset;
    logic       soft_reset;
    logic       write_enable;
    logic       lfd_state;
    logic [7:0] data_in;
    logic       read_enable;
    logic [7:0] data_out;
    logic       data_valid;
    logic       full;
    logic       empty;
    logic       almost_full;
    logic [4:0] fill_level;
    logic [6:0] rem_count;
    logic       pkt_end;
    logic       overflow_err;
    logic       underflow_err;

    int n_checks = 0;
    int n_errors = 0;

`ifdef ROUTER_FIFO_ERR_FLAGS_EN
    localparam logic c_ERR_ON = 1'b1;
`else
    localparam logic c_ERR_ON = 1'b0;
`endif

    router_pkt_fifo dut (
        .clk           (clk),
        .reset         (reset),
        .soft_reset    (soft_reset),
        .write_enable  (write_enable),
        .lfd_state     (lfd_state),
        .data_in       (data_in),
        .read_enable   (read_enable),
        .data_out      (data_out),
        .data_valid    (data_valid),
        .full          (full),
        .empty         (empty),
        .almost_full   (almost_full),
        .fill_level    (fill_level),
        .rem_count     (rem_count),
        .pkt_end       (pkt_end),
        .overflow_err  (overflow_err),
        .underflow_err (underflow_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [7:0] d, input logic sof);
        write_enable = 1'b1;
        lfd_state    = sof;
        data_in      = d;
        tick();
        write_enable = 1'b0;
        lfd_state    = 1'b0;
    endtask

    initial begin
        reset        = 1'b1;
        soft_reset   = 1'b0;
        write_enable = 1'b0;
        lfd_state    = 1'b0;
        data_in      = '0;
        read_enable  = 1'b0;
        tick();
        tick();
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_fill", 32'(fill_level), 32'd0);
        chk("rst_dv", 32'(data_valid), 32'd0);
        chk("rst_rem", 32'(rem_count), 32'd0);
        reset = 1'b0;
        tick();

        // Reset mid-traffic
        for (int i = 0; i < 5; i++) wr(8'hA1 + 8'(i), 1'b0);
        chk("mid_fill5", 32'(fill_level), 32'd5);
        read_enable = 1'b1;
        tick();
        read_enable = 1'b0;
        chk("mid_rd_data", 32'(data_out), 32'hA1);
        chk("mid_rd_dv", 32'(data_valid), 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("async_empty", 32'(empty), 32'd1);
        chk("async_fill", 32'(fill_level), 32'd0);
        chk("async_dout", 32'(data_out), 32'd0);
        chk("async_dv", 32'(data_valid), 32'd0);
        tick();
        reset = 1'b0;
        tick();

        // Single packet: header length 3, three payload words, parity
        wr(8'h0D, 1'b1);
        wr(8'h11, 1'b0);
        wr(8'h22, 1'b0);
        wr(8'h33, 1'b0);
        wr(8'h44, 1'b0);
        read_enable = 1'b1;
        tick();
        chk("pkt0_data", 32'(data_out), 32'h0D);
        chk("pkt0_rem", 32'(rem_count), 32'd4);
        chk("pkt0_end", 32'(pkt_end), 32'd0);
        tick();
        chk("pkt1_data", 32'(data_out), 32'h11);
        chk("pkt1_rem", 32'(rem_count), 32'd3);
        tick();
        chk("pkt2_data", 32'(data_out), 32'h22);
        chk("pkt2_rem", 32'(rem_count), 32'd2);
        tick();
        chk("pkt3_data", 32'(data_out), 32'h33);
        chk("pkt3_rem", 32'(rem_count), 32'd1);
        chk("pkt3_end", 32'(pkt_end), 32'd0);
        tick();
        read_enable = 1'b0;
        chk("pkt4_data", 32'(data_out), 32'h44);
        chk("pkt4_rem", 32'(rem_count), 32'd0);
        chk("pkt4_end", 32'(pkt_end), 32'd1);
        chk("pkt4_dv", 32'(data_valid), 32'd1);
        tick();
        chk("pkt_idle_dv", 32'(data_valid), 32'd0);
        chk("pkt_idle_end", 32'(pkt_end), 32'd0);
        chk("pkt_idle_hold", 32'(data_out), 32'h44);
        chk("pkt_idle_empty", 32'(empty), 32'd1);

        // Full boundary: 17 writes, the last one dropped
        for (int i = 0; i < 17; i++) begin
            wr(8'(i), 1'b0);
            if (i == 12) chk("af_at13", 32'(almost_full), 32'd0);
            if (i == 13) chk("af_at14", 32'(almost_full), 32'd1);
            if (i == 14) chk("full_at15", 32'(full), 32'd0);
            if (i == 15) chk("full_at16", 32'(full), 32'd1);
        end
        chk("full_fill16", 32'(fill_level), 32'd16);
        chk("full_still", 32'(full), 32'd1);
        chk("ovf_flag", 32'(overflow_err), 32'(c_ERR_ON));
        read_enable = 1'b1;
        for (int i = 0; i < 16; i++) begin
            tick();
            chk("drain_data", 32'(data_out), 32'(i));
        end
        read_enable = 1'b0;
        chk("orphan_rem", 32'(rem_count), 32'd0);
        chk("drain_empty", 32'(empty), 32'd1);

        // Simultaneous read/write at fill level 8 across pointer wrap
        for (int i = 0; i < 8; i++) wr(8'h50 + 8'(i), 1'b0);
        write_enable = 1'b1;
        read_enable  = 1'b1;
        for (int k = 0; k < 20; k++) begin
            data_in = 8'h58 + 8'(k);
            tick();
            chk("rw_data", 32'(data_out), 32'h50 + 32'(k));
            chk("rw_fill", 32'(fill_level), 32'd8);
        end
        write_enable = 1'b0;
        for (int j = 0; j < 8; j++) begin
            tick();
            chk("rw_drain", 32'(data_out), 32'h64 + 32'(j));
        end
        read_enable = 1'b0;

        // Read from empty, then simultaneous read/write on empty
        chk("emp_before", 32'(empty), 32'd1);
        read_enable = 1'b1;
        tick();
        chk("emp_rd_dv", 32'(data_valid), 32'd0);
        chk("emp_rd_hold", 32'(data_out), 32'h6B);
        chk("udf_flag", 32'(underflow_err), 32'(c_ERR_ON));
        write_enable = 1'b1;
        data_in      = 8'h77;
        tick();
        write_enable = 1'b0;
        chk("emp_rw_dv", 32'(data_valid), 32'd0);
        chk("emp_rw_fill", 32'(fill_level), 32'd1);
        tick();
        read_enable = 1'b0;
        chk("emp_next_dv", 32'(data_valid), 32'd1);
        chk("emp_next_data", 32'(data_out), 32'h77);
        chk("emp_next_empty", 32'(empty), 32'd1);

        // soft_reset with 6 words stored and rem_count 3
        wr(8'h14, 1'b1);
        for (int i = 0; i < 9; i++) wr(8'h80 + 8'(i), 1'b0);
        read_enable = 1'b1;
        tick();
        chk("sr_rem6", 32'(rem_count), 32'd6);
        tick();
        tick();
        tick();
        read_enable = 1'b0;
        chk("sr_rem3", 32'(rem_count), 32'd3);
        chk("sr_fill6", 32'(fill_level), 32'd6);
        soft_reset   = 1'b1;
        write_enable = 1'b1;
        read_enable  = 1'b1;
        data_in      = 8'h99;
        tick();
        soft_reset   = 1'b0;
        write_enable = 1'b0;
        chk("sr_empty", 32'(empty), 32'd1);
        chk("sr_fill", 32'(fill_level), 32'd0);
        chk("sr_rem", 32'(rem_count), 32'd0);
        chk("sr_dv", 32'(data_valid), 32'd0);
        chk("sr_dout", 32'(data_out), 32'd0);
        chk("sr_ovf", 32'(overflow_err), 32'd0);
        chk("sr_udf", 32'(underflow_err), 32'd0);
        tick();
        read_enable = 1'b0;
        chk("sr_after_dv", 32'(data_valid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
